// File: rtl/fifo_access_arbiter_if.sv
// rtl/fifo_access_arbiter_if.sv - requester, consumer and FIFO-side signals of fifo_access_arbiter
interface fifo_access_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [1:0]       Wr_Req;
  logic [WIDTH-1:0] Wr_Data0;
  logic [WIDTH-1:0] Wr_Data1;
  logic [1:0]       Wr_Gnt;
  logic             Rd_Req;
  logic             Rd_Gnt;
  logic [WIDTH-1:0] Rd_Data;
  logic             Rd_Valid;
  logic [LW-1:0]    Level;
  logic             Error;
  logic [WIDTH-1:0] FIFO_Input;
  logic             FIFO_Read_Write;
  logic             FIFO_Enable;
  logic [WIDTH-1:0] FIFO_Output;
  logic             FIFO_Empty;
  logic             FIFO_Full;

  modport master (
    input  Wr_Req, Wr_Data0, Wr_Data1, Rd_Req, FIFO_Output, FIFO_Empty, FIFO_Full,
    output Wr_Gnt, Rd_Gnt, Rd_Data, Rd_Valid, Level, Error,
           FIFO_Input, FIFO_Read_Write, FIFO_Enable
  );

  modport slave (
    output Wr_Req, Wr_Data0, Wr_Data1, Rd_Req, FIFO_Output, FIFO_Empty, FIFO_Full,
    input  Wr_Gnt, Rd_Gnt, Rd_Data, Rd_Valid, Level, Error,
           FIFO_Input, FIFO_Read_Write, FIFO_Enable
  );
endinterface

// File: rtl/fifo_access_arbiter.sv
// rtl/fifo_access_arbiter.sv - round-robin arbiter sharing one FIFO between two writers and one reader
module fifo_access_arbiter #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32
) (
  input logic                   CLK,
  input logic                   Reset,
  fifo_access_arbiter_if.master bus
);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] ONE      = LW'(1);
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  localparam logic [1:0] SRC_W0 = 2'd0;
  localparam logic [1:0] SRC_W1 = 2'd1;
  localparam logic [1:0] SRC_R  = 2'd2;

  logic [1:0]       last_q;
  logic [WIDTH-1:0] rd_data_q;
  logic             rd_valid_q;
  logic [LW-1:0]    level_q;
  logic             error_q;

  logic e_w0, e_w1, e_r;
  logic g_w0, g_w1, g_r;
  logic wr_gnt_any;
  logic mismatch;

  assign e_w0 = bus.Wr_Req[0] & ~bus.FIFO_Full;
  assign e_w1 = bus.Wr_Req[1] & ~bus.FIFO_Full;
  assign e_r  = bus.Rd_Req & ~bus.FIFO_Empty;

  // Search starts at the source just after the last one granted.
  always_comb begin
    g_w0 = 1'b0;
    g_w1 = 1'b0;
    g_r  = 1'b0;
    if (!Reset) begin
      case (last_q)
        SRC_W0: begin
          if (e_w1)      g_w1 = 1'b1;
          else if (e_r)  g_r  = 1'b1;
          else if (e_w0) g_w0 = 1'b1;
        end
        SRC_W1: begin
          if (e_r)       g_r  = 1'b1;
          else if (e_w0) g_w0 = 1'b1;
          else if (e_w1) g_w1 = 1'b1;
        end
        default: begin
          if (e_w0)      g_w0 = 1'b1;
          else if (e_w1) g_w1 = 1'b1;
          else if (e_r)  g_r  = 1'b1;
        end
      endcase
    end
  end

  assign wr_gnt_any = g_w0 | g_w1;
  assign mismatch   = ((level_q == '0) != bus.FIFO_Empty) ||
                      ((level_q == FULL_LVL) != bus.FIFO_Full);

  assign bus.Wr_Gnt          = {g_w1, g_w0};
  assign bus.Rd_Gnt          = g_r;
  assign bus.FIFO_Enable     = wr_gnt_any | g_r;
  assign bus.FIFO_Read_Write = wr_gnt_any;
  assign bus.FIFO_Input      = g_w0 ? bus.Wr_Data0 : (g_w1 ? bus.Wr_Data1 : '0);
  assign bus.Rd_Data         = rd_data_q;
  assign bus.Rd_Valid        = rd_valid_q;
  assign bus.Level           = level_q;
  assign bus.Error           = error_q;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      last_q     <= SRC_R;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      level_q    <= '0;
      error_q    <= 1'b0;
    end else begin
      if (g_w0)      last_q <= SRC_W0;
      else if (g_w1) last_q <= SRC_W1;
      else if (g_r)  last_q <= SRC_R;

      rd_valid_q <= g_r;
      if (g_r) rd_data_q <= bus.FIFO_Output;

      case ({wr_gnt_any, g_r})
        2'b10:   level_q <= level_q + ONE;
        2'b01:   level_q <= level_q - ONE;
        default: ;
      endcase

      error_q <= error_q | mismatch;
    end
  end
endmodule
